// File: rtl/snake_pkg.sv
// Shared types, direction codes, colours and width helpers for the snake body renderer.
package snake_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t COLOR_HEAD = 12'hFF0;
    localparam rgb_t COLOR_BODY = 12'h0F0;
    localparam rgb_t COLOR_DEAD = 12'hF00;
    localparam rgb_t COLOR_OFF  = 12'h000;

    function automatic dir_t opposite_dir(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_NONE;
        endcase
    endfunction

    // Bits needed to hold a grid coordinate 0..n-1.
    function automatic int coord_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/snake_body_renderer_if.sv
// Control-packet stream from the packet router into the snake renderer.
interface snake_body_renderer_if;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/snake_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, on the wrap of the counter.
module snake_tick_gen #(
    parameter int TICK_DIV = 6250000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic tick
);
    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign tick = (cnt_reg == LAST);
endmodule

// File: rtl/snake_body_renderer.sv
// Multi-segment grid snake: direction control, growth, collision and VGA layer rendering.
// Build option SNAKE_WRAP_EN: walls wrap around the grid instead of being fatal.
module snake_body_renderer
    import snake_pkg::*;
#(
    parameter int CELL_SHIFT = 5,
    parameter int GRID_W     = 20,
    parameter int GRID_H     = 15,
    parameter int MAX_LEN    = 16,
    parameter int INIT_LEN   = 3,
    parameter int TICK_DIV   = 6250000
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    snake_body_renderer_if.slave               s_axis,
    input  logic                               i_grow,
    input  logic [9:0]                         i_pixel_x,
    input  logic [9:0]                         i_pixel_y,
    input  logic                               i_video_on,
    output logic [3:0]                         o_vga_r,
    output logic [3:0]                         o_vga_g,
    output logic [3:0]                         o_vga_b,
    output logic [coord_width(GRID_W)-1:0]     o_head_x,
    output logic [coord_width(GRID_H)-1:0]     o_head_y,
    output logic [$clog2(MAX_LEN+1)-1:0]       o_len,
    output logic                               o_dead
);
    localparam int XW = coord_width(GRID_W);
    localparam int YW = coord_width(GRID_H);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic          tick;
    dir_t          heading_reg, pending_reg;
    logic          grow_pending_reg;
    logic [LW-1:0] len_reg;
    logic          dead_reg;
    logic [XW-1:0] seg_x_reg [MAX_LEN];
    logic [YW-1:0] seg_y_reg [MAX_LEN];
    rgb_t          rgb_reg, rgb_next;

    snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .tick    (tick)
    );

    assign s_axis.tready = 1'b1;

    // Direction decode; reversal is judged against the committed heading only.
    logic [7:0] dir_code;
    dir_t       dir_in;
    logic       dir_accept;

    assign dir_code = s_axis.tdata[15:8];

    always_comb begin
        dir_in     = DIR_NONE;
        dir_accept = 1'b0;
        if (s_axis.tvalid && s_axis.tlast && (dir_code inside {[8'd1:8'd4]})) begin
            dir_in     = dir_t'(dir_code[2:0]);
            dir_accept = (dir_in != opposite_dir(heading_reg));
        end
    end

    // Candidate head position for the next move.
    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;
    logic          wall_hit;

    always_comb begin
        next_x   = seg_x_reg[0];
        next_y   = seg_y_reg[0];
        wall_hit = 1'b0;
        case (pending_reg)
            DIR_UP: begin
                if (seg_y_reg[0] == '0) begin
`ifdef SNAKE_WRAP_EN
                    next_y = YW'(GRID_H - 1);
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    next_y = seg_y_reg[0] - YW'(1);
                end
            end
            DIR_DOWN: begin
                if (seg_y_reg[0] == YW'(GRID_H - 1)) begin
`ifdef SNAKE_WRAP_EN
                    next_y = '0;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    next_y = seg_y_reg[0] + YW'(1);
                end
            end
            DIR_LEFT: begin
                if (seg_x_reg[0] == '0) begin
`ifdef SNAKE_WRAP_EN
                    next_x = XW'(GRID_W - 1);
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    next_x = seg_x_reg[0] - XW'(1);
                end
            end
            DIR_RIGHT: begin
                if (seg_x_reg[0] == XW'(GRID_W - 1)) begin
`ifdef SNAKE_WRAP_EN
                    next_x = '0;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    next_x = seg_x_reg[0] + XW'(1);
                end
            end
            default: ;
        endcase
    end

    // A full-length snake consumes the grow but still vacates its tail.
    logic          grow_eff;
    logic [LW-1:0] hit_limit;
    logic [MAX_LEN-1:0] body_hit;
    logic          collide;
    logic          move;

    assign grow_eff  = (grow_pending_reg || i_grow) && (len_reg != LW'(MAX_LEN));
    assign hit_limit = grow_eff ? len_reg : len_reg - LW'(1);

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_self_hit
            assign body_hit[gi] = (LW'(gi) < hit_limit)
                               && (seg_x_reg[gi] == next_x)
                               && (seg_y_reg[gi] == next_y);
        end
    endgenerate

    assign collide = wall_hit || (|body_hit);
    assign move    = tick && !dead_reg && !collide;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            heading_reg      <= DIR_RIGHT;
            pending_reg      <= DIR_RIGHT;
            grow_pending_reg <= 1'b0;
            len_reg          <= LW'(INIT_LEN);
            dead_reg         <= 1'b0;
        end else begin
            if (dir_accept && !dead_reg) begin
                pending_reg <= dir_in;
            end
            if (tick && !dead_reg) begin
                heading_reg      <= pending_reg;
                grow_pending_reg <= 1'b0;
                if (collide) begin
                    dead_reg <= 1'b1;
                end else if (grow_eff) begin
                    len_reg <= len_reg + LW'(1);
                end
            end else if (i_grow) begin
                grow_pending_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_reg[i] <= (i < INIT_LEN) ? XW'(GRID_W / 2 - i) : '0;
                seg_y_reg[i] <= (i < INIT_LEN) ? YW'(GRID_H / 2) : '0;
            end
        end else if (move) begin
            seg_x_reg[0] <= next_x;
            seg_y_reg[0] <= next_y;
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_x_reg[i] <= seg_x_reg[i-1];
                seg_y_reg[i] <= seg_y_reg[i-1];
            end
        end
    end

    // Pixel-to-cell match against every live segment.
    logic [9:0]         cell_x, cell_y;
    logic [MAX_LEN-1:0] pix_hit;
    logic               head_pix, body_pix;

    assign cell_x = i_pixel_x >> CELL_SHIFT;
    assign cell_y = i_pixel_y >> CELL_SHIFT;

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_pix_hit
            assign pix_hit[gi] = (LW'(gi) < len_reg)
                              && (cell_x == 10'(seg_x_reg[gi]))
                              && (cell_y == 10'(seg_y_reg[gi]));
        end
    endgenerate

    assign head_pix = pix_hit[0];
    assign body_pix = |pix_hit[MAX_LEN-1:1];

    always_comb begin
        rgb_next = COLOR_OFF;
        if (i_video_on && (head_pix || body_pix)) begin
            if (dead_reg) begin
                rgb_next = COLOR_DEAD;
            end else if (head_pix) begin
                rgb_next = COLOR_HEAD;
            end else begin
                rgb_next = COLOR_BODY;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rgb_reg <= COLOR_OFF;
        end else begin
            rgb_reg <= rgb_next;
        end
    end

    assign o_vga_r  = rgb_reg.r;
    assign o_vga_g  = rgb_reg.g;
    assign o_vga_b  = rgb_reg.b;
    assign o_head_x = seg_x_reg[0];
    assign o_head_y = seg_y_reg[0];
    assign o_len    = len_reg;
    assign o_dead   = dead_reg;

    logic unused_bits;
    assign unused_bits = ^{s_axis.tdata[63:16], s_axis.tdata[7:0]};
endmodule
